// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared definitions for the 4x4 matrix keypad scanner.
//               - FSM state encoding (2 bits)
//               - Row drive table (active-low one-hot, indexed by row number)
//               - Default timing parameters for a 10 kHz scan clock
//               - Column decode helpers used by the scanner datapath
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    // Scanner FSM states, explicitly encoded so the register width is fixed.
    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } kp_state_t;

    // Default timing at 10 kHz: 0.4 ms per row, 20 ms debounce window.
    localparam int c_SCAN_DWELL_DEFAULT      = 4;
    localparam int c_DEBOUNCE_CYCLES_DEFAULT = 200;

    // Column lines are pulled up, so "no key" reads as all ones.
    localparam logic [3:0] c_COL_IDLE = 4'b1111;

    // Row drive pattern for each row index; element [0] drives row 0 low.
    localparam logic [3:0][3:0] c_ROW_DRIVE = {
        4'b0111,    // row 3
        4'b1011,    // row 2
        4'b1101,    // row 1
        4'b1110     // row 0
    };

    // Result of decoding a column sample: hit is set only when exactly
    // one column is low, and idx is then that column's number.
    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
    } col_hit_t;

    function automatic col_hit_t decode_col(input logic [3:0] col);
        col_hit_t res;
        res.hit = 1'b1;
        res.idx = 2'd0;
        case (col)
            4'b1110: res.idx = 2'd0;
            4'b1101: res.idx = 2'd1;
            4'b1011: res.idx = 2'd2;
            4'b0111: res.idx = 2'd3;
            // No key, or two or more columns low (ghosting / multi-key).
            default: res.hit = 1'b0;
        endcase
        return res;
    endfunction

    // Active-low one-hot column pattern expected while a single key is held.
    function automatic logic [3:0] col_pattern(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage : keypad_pkg
`default_nettype wire

// File: rtl/keypad_col_sync.sv
`default_nettype none
// ============================================================================
// Module      : keypad_col_sync
// Description : Two-flop synchronizer for the asynchronous keypad column
//               lines. Both stages reset to all ones, which is the released
//               (pulled-up) level, so reset never looks like a key press.
// Ports       : Clock_Div_10000Hz - scan clock
//               Reset_n           - asynchronous active-low reset
//               i_col             - raw column lines (asynchronous)
//               o_col_s           - synchronized column lines
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_col_sync #(
    parameter int WIDTH = 4
) (
    input  logic             Clock_Div_10000Hz,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] i_col,
    output logic [WIDTH-1:0] o_col_s
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge Clock_Div_10000Hz or negedge Reset_n) begin
        if (!Reset_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_col;
            r_sync <= r_meta;
        end
    end

    assign o_col_s = r_sync;

endmodule : keypad_col_sync
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : 4x4 matrix keypad scanner with press and release debounce.
//               Rows are driven low one at a time; columns are sampled at
//               the end of each row's dwell. A single low column latches
//               the key, which must then stay stable for DEBOUNCE_CYCLES
//               cycles before it is reported. Release is debounced the same
//               way before scanning resumes at the next row.
// Ports       : Clock_Div_10000Hz - sole clock (10 kHz)
//               Reset_n           - asynchronous active-low reset
//               Key_Col[3:0]      - column lines, active-low, asynchronous
//               Key_Row[3:0]      - row drive, active-low one-hot
//               Key_Code[3:0]     - last accepted key, row*4 + col
//               Key_Valid         - one-cycle pulse on accepted press
//               Key_Held          - high from accepted press to accepted
//                                   release
// Parameters  : SCAN_DWELL        - cycles per row while scanning; must be
//                                   at least 3 so the synchronizer has
//                                   flushed the previous row's columns by
//                                   the time the sample is taken
//               DEBOUNCE_CYCLES   - stable cycles to accept press/release
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DWELL      = c_SCAN_DWELL_DEFAULT,
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       Clock_Div_10000Hz,
    input  logic       Reset_n,
    input  logic [3:0] Key_Col,
    output logic [3:0] Key_Row,
    output logic [3:0] Key_Code,
    output logic       Key_Valid,
    output logic       Key_Held
);

    // ------------------------------------------------------------------------
    // Counter sizing
    // ------------------------------------------------------------------------
    localparam int c_DWELL_W = (SCAN_DWELL > 1) ? $clog2(SCAN_DWELL) : 1;
    localparam int c_CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [c_DWELL_W-1:0] c_DWELL_LAST = c_DWELL_W'(SCAN_DWELL - 1);
    localparam logic [c_CNT_W-1:0]   c_CNT_MAX    = c_CNT_W'(DEBOUNCE_CYCLES);

    // ------------------------------------------------------------------------
    // Column synchronizer
    // ------------------------------------------------------------------------
    logic [3:0] w_col_s;

    keypad_col_sync #(
        .WIDTH (4)
    ) u_col_sync (
        .Clock_Div_10000Hz (Clock_Div_10000Hz),
        .Reset_n           (Reset_n),
        .i_col             (Key_Col),
        .o_col_s           (w_col_s)
    );

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    kp_state_t            r_state;
    logic [1:0]           r_row_idx;
    logic [1:0]           r_col_idx;
    logic [c_DWELL_W-1:0] r_dwell_cnt;
    logic [c_CNT_W-1:0]   r_dbc_cnt;
    logic [3:0]           r_key_code;
    logic                 r_key_valid;
    logic                 r_key_held;

    kp_state_t            w_state_nxt;
    logic [1:0]           w_row_idx_nxt;
    logic [1:0]           w_col_idx_nxt;
    logic [c_DWELL_W-1:0] w_dwell_cnt_nxt;
    logic [c_CNT_W-1:0]   w_dbc_cnt_nxt;
    logic [3:0]           w_key_code_nxt;
    logic                 w_key_valid_nxt;
    logic                 w_key_held_nxt;

    // ------------------------------------------------------------------------
    // Column qualifiers
    // ------------------------------------------------------------------------
    col_hit_t           w_col_hit;
    logic               w_col_match;
    logic               w_col_idle;
    logic [c_CNT_W-1:0] w_dbc_inc;
    logic               w_dbc_done;
    logic               w_dwell_last;

    assign w_col_hit    = decode_col(w_col_s);
    assign w_col_match  = (w_col_s == col_pattern(r_col_idx));
    assign w_col_idle   = (w_col_s == c_COL_IDLE);
    assign w_dwell_last = (r_dwell_cnt == c_DWELL_LAST);

    // Saturating increment: the debounce counter never wraps back to zero.
    assign w_dbc_inc  = (r_dbc_cnt == c_CNT_MAX) ? r_dbc_cnt : (r_dbc_cnt + 1'b1);
    // The cycle that brings the count to DEBOUNCE_CYCLES is the accepting one.
    assign w_dbc_done = (w_dbc_inc == c_CNT_MAX);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge Clock_Div_10000Hz or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= ST_SCAN;
            r_row_idx   <= 2'd0;
            r_col_idx   <= 2'd0;
            r_dwell_cnt <= '0;
            r_dbc_cnt   <= '0;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_row_idx   <= w_row_idx_nxt;
            r_col_idx   <= w_col_idx_nxt;
            r_dwell_cnt <= w_dwell_cnt_nxt;
            r_dbc_cnt   <= w_dbc_cnt_nxt;
            r_key_code  <= w_key_code_nxt;
            r_key_valid <= w_key_valid_nxt;
            r_key_held  <= w_key_held_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_row_idx_nxt   = r_row_idx;
        w_col_idx_nxt   = r_col_idx;
        w_dwell_cnt_nxt = r_dwell_cnt;
        w_dbc_cnt_nxt   = r_dbc_cnt;
        w_key_code_nxt  = r_key_code;
        w_key_valid_nxt = 1'b0;
        w_key_held_nxt  = r_key_held;

        case (r_state)
            ST_SCAN: begin
                if (w_dwell_last) begin
                    w_dwell_cnt_nxt = '0;
                    if (w_col_hit.hit) begin
                        // Single key on this row: keep the row driven and
                        // start qualifying it.
                        w_col_idx_nxt = w_col_hit.idx;
                        w_dbc_cnt_nxt = '0;
                        w_state_nxt   = ST_DEBOUNCE;
                    end else begin
                        // Nothing, or a ghost/multi-key pattern: move on.
                        w_row_idx_nxt = r_row_idx + 2'd1;
                    end
                end else begin
                    w_dwell_cnt_nxt = r_dwell_cnt + 1'b1;
                end
            end

            ST_DEBOUNCE: begin
                if (w_col_match) begin
                    w_dbc_cnt_nxt = w_dbc_inc;
                    if (w_dbc_done) begin
                        w_state_nxt     = ST_PRESSED;
                        w_dbc_cnt_nxt   = '0;
                        w_key_code_nxt  = {r_row_idx, r_col_idx};
                        w_key_valid_nxt = 1'b1;
                        w_key_held_nxt  = 1'b1;
                    end
                end else begin
                    // Bounce or glitch: abandon this key and resume at the
                    // following row so one noisy key cannot starve the rest.
                    w_state_nxt     = ST_SCAN;
                    w_row_idx_nxt   = r_row_idx + 2'd1;
                    w_dwell_cnt_nxt = '0;
                    w_dbc_cnt_nxt   = '0;
                end
            end

            ST_PRESSED: begin
                // Other columns going low on the held row are ignored; only
                // a fully idle column bus starts release qualification.
                if (w_col_idle) begin
                    w_state_nxt   = ST_RELEASE;
                    w_dbc_cnt_nxt = '0;
                end
            end

            ST_RELEASE: begin
                if (w_col_idle) begin
                    w_dbc_cnt_nxt = w_dbc_inc;
                    if (w_dbc_done) begin
                        w_state_nxt     = ST_SCAN;
                        w_key_held_nxt  = 1'b0;
                        w_row_idx_nxt   = r_row_idx + 2'd1;
                        w_dwell_cnt_nxt = '0;
                        w_dbc_cnt_nxt   = '0;
                    end
                end else begin
                    // Release bounce: still the same press, no new pulse.
                    w_state_nxt   = ST_PRESSED;
                    w_dbc_cnt_nxt = '0;
                end
            end

            default: begin
                w_state_nxt = ST_SCAN;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign Key_Row   = c_ROW_DRIVE[r_row_idx];
    assign Key_Code  = r_key_code;
    assign Key_Valid = r_key_valid;
    assign Key_Held  = r_key_held;

endmodule : keypad_scanner
`default_nettype wire
